// File: rtl/vsync_decoder.sv
// vsync_decoder: receiving end of the TTL timing chain.
// Turns the HRESET/VRESET strobes into a line number, the length of the last
// frame and a frame-lock indication. The downstream video stage only draws
// while LOCKED is high.
//
// LINE and FRAME_LEN are LINE_W bits wide, sized from LINES so that they can
// carry the 2*LINES-1 timeout length (10 bits for the 262-line Pong raster).
module vsync_decoder #(
   parameter  int LINES         = 262,
   parameter  int PIXELS        = 455,
   parameter  int LOCK_FRAMES   = 2,
   parameter  int UNLOCK_FRAMES = 2,
   localparam int LINE_W        = $clog2(2 * LINES)
) (
   input  logic              CLK,
   input  logic              CLR_N,
   input  logic              HRESET,
   input  logic              VRESET,
   output logic [LINE_W-1:0] LINE,
   output logic [LINE_W-1:0] FRAME_LEN,
   output logic              LOCKED,
   output logic              FRAME_STB,
   output logic              FRAME_ERR,
   output logic              LINE_ERR
);

   // Lock state machine encoding
   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_ACQUIRE = 2'd1;
   localparam logic [1:0] S_LOCKED  = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   // Length a frame is cut off at when no VRESET arrives
   localparam logic [LINE_W-1:0] TIMEOUT_LEN = LINE_W'(2 * LINES - 1);
   localparam logic [LINE_W-1:0] GOOD_LEN    = LINE_W'(LINES);

   // Pixel counter saturates instead of wrapping so a missing HRESET
   // can never alias back onto a correct line length.
   localparam logic [9:0] PIX_MAX  = 10'd1023;
   localparam logic [9:0] PIX_GOOD = 10'(PIXELS - 1);

   localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
   localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_FRAMES);

   // Strobe synchronisers and edge flags
   logic r_h_sync;
   logic r_h_dly;
   logic r_h_edge;
   logic r_v_sync;
   logic r_v_dly;
   logic r_v_edge;

   // Line length measurement
   logic [9:0] r_pix_cnt;
   logic       r_h_seen;

   // Lock state
   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_good_cnt;
   logic [7:0] w_good_nxt;
   logic [7:0] r_bad_cnt;
   logic [7:0] w_bad_nxt;
   logic       w_frame_err;
   logic       w_locked_nxt;

   // Frame bookkeeping
   logic [LINE_W-1:0] w_line_inc;
   logic [LINE_W-1:0] w_frame_len;
   logic              w_timeout;
   logic              w_frame_end;
   logic              w_frame_good;
   logic              w_line_bad;

   // Register both strobes, then flag a rising edge against the delayed copy.
   // A level held for several cycles therefore produces exactly one edge flag.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the clock edge, independent of block order.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_h_sync <= 1'b0;
         r_h_dly  <= 1'b0;
         r_h_edge <= 1'b0;
         r_v_sync <= 1'b0;
         r_v_dly  <= 1'b0;
         r_v_edge <= 1'b0;
      end else begin
         r_h_sync <= HRESET;
         r_h_dly  <= r_h_sync;
         r_h_edge <= r_h_sync & ~r_h_dly;
         r_v_sync <= VRESET;
         r_v_dly  <= r_v_sync;
         r_v_edge <= r_v_sync & ~r_v_dly;
      end
   end

   // Frame length and line judgement, derived from the edge flags
   assign w_line_inc   = LINE + LINE_W'(1);
   assign w_frame_len  = r_h_edge ? w_line_inc : LINE;
   assign w_timeout    = r_h_edge & ~r_v_edge & (w_line_inc == TIMEOUT_LEN);
   assign w_frame_end  = r_v_edge | w_timeout;
   assign w_frame_good = r_v_edge & (w_frame_len == GOOD_LEN);
   assign w_line_bad   = r_h_edge & r_h_seen & (r_pix_cnt != PIX_GOOD);

   // Count clocks between line edges; the very first edge has no reference.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_pix_cnt <= '0;
         r_h_seen  <= 1'b0;
      end else begin
         if (r_h_edge) begin
            r_pix_cnt <= '0;
            r_h_seen  <= 1'b1;
         end else if (r_pix_cnt != PIX_MAX) begin
            r_pix_cnt <= r_pix_cnt + 10'd1;
         end
      end
   end

   // Line counter and last-frame length; a timeout ends the frame like VRESET.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         LINE      <= '0;
         FRAME_LEN <= '0;
      end else begin
         if (w_frame_end) begin
            LINE      <= '0;
            FRAME_LEN <= w_frame_len;
         end else if (r_h_edge) begin
            LINE <= w_line_inc;
         end
      end
   end

   // Next-state logic of the lock machine, evaluated once per frame end.
   // NOTE: every signal written here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_bad_nxt   = r_bad_cnt;
      w_frame_err = 1'b0;
      if (w_frame_end) begin
         case (r_state)
            S_SEARCH: begin
               // The partial frame seen while searching is never judged.
               if (r_v_edge) begin
                  w_state_nxt = S_ACQUIRE;
                  w_good_nxt  = '0;
               end
            end
            S_ACQUIRE: begin
               if (w_frame_good) begin
                  w_good_nxt = r_good_cnt + 8'd1;
                  if (r_good_cnt + 8'd1 >= LOCK_N) begin
                     w_state_nxt = S_LOCKED;
                     w_bad_nxt   = '0;
                  end
               end else begin
                  w_good_nxt  = '0;
                  w_frame_err = 1'b1;
               end
            end
            S_LOCKED: begin
               if (!w_frame_good) begin
                  w_frame_err = 1'b1;
                  w_bad_nxt   = 8'd1;
                  if (8'd1 >= UNLOCK_N) begin
                     w_state_nxt = S_ACQUIRE;
                     w_good_nxt  = '0;
                  end else begin
                     w_state_nxt = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (w_frame_good) begin
                  w_state_nxt = S_LOCKED;
                  w_bad_nxt   = '0;
               end else begin
                  w_frame_err = 1'b1;
                  w_bad_nxt   = r_bad_cnt + 8'd1;
                  if (r_bad_cnt + 8'd1 >= UNLOCK_N) begin
                     w_state_nxt = S_ACQUIRE;
                     w_good_nxt  = '0;
                     w_bad_nxt   = '0;
                  end
               end
            end
            default: begin
               w_state_nxt = S_SEARCH;
               w_good_nxt  = '0;
               w_bad_nxt   = '0;
            end
         endcase
      end
   end

   // HOLD still reports lock: one bad frame must not blank the picture.
   assign w_locked_nxt = (w_state_nxt == S_LOCKED) || (w_state_nxt == S_HOLD);

   // Lock machine state registers
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state    <= S_SEARCH;
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
         r_bad_cnt  <= w_bad_nxt;
      end
   end

   // Registered status and one-cycle pulses; LOCKED moves with the deciding pulse.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         LOCKED    <= 1'b0;
         FRAME_STB <= 1'b0;
         FRAME_ERR <= 1'b0;
         LINE_ERR  <= 1'b0;
      end else begin
         LOCKED    <= w_locked_nxt;
         FRAME_STB <= r_v_edge;
         FRAME_ERR <= w_frame_err;
         LINE_ERR  <= w_line_bad;
      end
   end

endmodule

// File: tb/tb_vsync_decoder.sv
// tb_vsync_decoder: scoreboard bench for vsync_decoder.
// A scaled raster keeps run time short. The reference model works on strobe
// timestamps and frame verdicts; a monitor pops one expected event every time
// the DUT shows a pulse or a new LINE value.
module tb_vsync_decoder;

   localparam int LINES         = 10;
   localparam int PIXELS        = 16;
   localparam int LOCK_FRAMES   = 2;
   localparam int UNLOCK_FRAMES = 2;
   localparam int LW            = $clog2(2 * LINES);
   localparam int TIMEOUT       = 2 * LINES - 1;

   logic          CLK    = 1'b0;
   logic          CLR_N  = 1'b1;
   logic          HRESET = 1'b0;
   logic          VRESET = 1'b0;
   logic [LW-1:0] LINE;
   logic [LW-1:0] FRAME_LEN;
   logic          LOCKED;
   logic          FRAME_STB;
   logic          FRAME_ERR;
   logic          LINE_ERR;

   vsync_decoder #(
      .LINES        (LINES),
      .PIXELS       (PIXELS),
      .LOCK_FRAMES  (LOCK_FRAMES),
      .UNLOCK_FRAMES(UNLOCK_FRAMES)
   ) u_dut (
      .CLK      (CLK),
      .CLR_N    (CLR_N),
      .HRESET   (HRESET),
      .VRESET   (VRESET),
      .LINE     (LINE),
      .FRAME_LEN(FRAME_LEN),
      .LOCKED   (LOCKED),
      .FRAME_STB(FRAME_STB),
      .FRAME_ERR(FRAME_ERR),
      .LINE_ERR (LINE_ERR)
   );

   always #5 CLK = ~CLK;

   int unsigned edge_cnt = 0;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int unsigned t;
      bit          stb;
      bit          ferr;
      bit          lerr;
      bit          locked;
      int          line_no;
      int          flen;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model state
   bit          m_prev_h;
   bit          m_prev_v;
   bit          m_h_seen;
   bit          m_acq;
   bit          m_locked;
   int unsigned m_last_h;
   int          m_lines;
   int          m_flen;
   int          m_good_run;
   int          m_bad_run;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   task automatic model_reset();
      m_prev_h   = 1'b0;
      m_prev_v   = 1'b0;
      m_h_seen   = 1'b0;
      m_acq      = 1'b0;
      m_locked   = 1'b0;
      m_last_h   = 0;
      m_lines    = 0;
      m_flen     = 0;
      m_good_run = 0;
      m_bad_run  = 0;
      exp_q.delete();
   endtask

   // Lock verdict: count good frames until locked, bad frames until unlocked.
   task automatic model_judge(input bit good, output bit ferr);
      ferr = 1'b0;
      if (!m_locked) begin
         if (good) begin
            m_good_run++;
            if (m_good_run >= LOCK_FRAMES) begin
               m_locked  = 1'b1;
               m_bad_run = 0;
            end
         end else begin
            m_good_run = 0;
            ferr       = 1'b1;
         end
      end else begin
         if (good) begin
            m_bad_run = 0;
         end else begin
            ferr = 1'b1;
            m_bad_run++;
            if (m_bad_run >= UNLOCK_FRAMES) begin
               m_locked   = 1'b0;
               m_good_run = 0;
            end
         end
      end
   endtask

   // Feed one input sample taken at clock edge e; responses appear at e+2.
   task automatic model_sample(input bit h, input bit v, input int unsigned e);
      bit   he;
      bit   ve;
      bit   ferr;
      exp_t x;
      he       = h && !m_prev_h;
      ve       = v && !m_prev_v;
      m_prev_h = h;
      m_prev_v = v;
      if (!he && !ve) return;
      x.stb  = 1'b0;
      x.lerr = 1'b0;
      ferr   = 1'b0;
      if (he) begin
         if (m_h_seen && (e - m_last_h) != PIXELS) x.lerr = 1'b1;
         m_h_seen = 1'b1;
         m_last_h = e;
         m_lines++;
      end
      if (ve) begin
         x.stb   = 1'b1;
         m_flen  = m_lines;
         m_lines = 0;
         if (m_acq) model_judge(m_flen == LINES, ferr);
         else begin
            m_acq      = 1'b1;
            m_good_run = 0;
         end
      end else if (m_lines == TIMEOUT) begin
         m_flen  = TIMEOUT;
         m_lines = 0;
         if (m_acq) model_judge(1'b0, ferr);
      end
      x.t       = e + 2;
      x.ferr    = ferr;
      x.locked  = m_locked;
      x.line_no = m_lines;
      x.flen    = m_flen;
      exp_q.push_back(x);
   endtask

   // One clock of stimulus; called and returning 1 time unit after a rising edge.
   task automatic drive(input bit h, input bit v);
      HRESET = h;
      VRESET = v;
      @(posedge CLK);
      #1;
      if (CLR_N) model_sample(h, v, edge_cnt);
   endtask

   // One line: HRESET high for 'hold' clocks, period 'len'; optional VRESET pulse.
   task automatic send_line(input int len, input int hold, input bit v_on,
                            input int v_off, input int v_hold);
      for (int c = 0; c < len; c++)
         drive(c < hold, v_on && (c >= v_off) && (c < v_off + v_hold));
   endtask

   task automatic frame_std(input int n);
      for (int i = 0; i < n; i++) send_line(PIXELS, 1, i == n - 1, 0, 1);
   endtask

   task automatic random_frame();
      int kind;
      int n;
      int len;
      int v_off;
      bit with_v;
      bit last;
      kind   = $urandom_range(0, 9);
      with_v = (kind != 0);
      if (!with_v)      n = TIMEOUT + 2;
      else if (kind < 7) n = LINES;
      else              n = $urandom_range(LINES - 3, LINES + 3);
      for (int i = 0; i < n; i++) begin
         len   = ($urandom_range(0, 9) == 0) ? $urandom_range(PIXELS - 3, PIXELS + 3) : PIXELS;
         last  = with_v && (i == n - 1);
         v_off = last ? $urandom_range(0, len - 5) : 0;
         send_line(len, $urandom_range(1, 3), last, v_off, $urandom_range(1, 3));
      end
   endtask

   // Quiet-time comparison of the slow outputs against the model.
   task automatic status_check(input string tag);
      check({tag, "_locked"},    LOCKED,    m_locked);
      check({tag, "_line"},      LINE,      m_lines);
      check({tag, "_frame_len"}, FRAME_LEN, m_flen);
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic do_reset();
      HRESET = 1'b0;
      VRESET = 1'b0;
      #2 CLR_N = 1'b0;
      #1;
      check("rst_line",      LINE,      0);
      check("rst_frame_len", FRAME_LEN, 0);
      check("rst_locked",    LOCKED,    0);
      check("rst_frame_stb", FRAME_STB, 0);
      check("rst_frame_err", FRAME_ERR, 0);
      check("rst_line_err",  LINE_ERR,  0);
      model_reset();
      repeat (3) @(posedge CLK);
      #1 CLR_N = 1'b1;
   endtask

   // Monitor: every pulse or LINE change must match the oldest expected event.
   int prev_line = 0;
   always @(negedge CLK) begin
      if (!CLR_N) begin
         prev_line = 0;
      end else if (FRAME_STB === 1'b1 || FRAME_ERR === 1'b1 || LINE_ERR === 1'b1 ||
                   int'(LINE) != prev_line) begin
         check("event_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("ev_cycle",     edge_cnt,  mon_e.t);
            check("ev_frame_stb", FRAME_STB, mon_e.stb);
            check("ev_frame_err", FRAME_ERR, mon_e.ferr);
            check("ev_line_err",  LINE_ERR,  mon_e.lerr);
            check("ev_locked",    LOCKED,    mon_e.locked);
            check("ev_line",      LINE,      mon_e.line_no);
            check("ev_frame_len", FRAME_LEN, mon_e.flen);
         end
         prev_line = int'(LINE);
      end
   end

   initial begin
      model_reset();
      @(posedge CLK);
      #1;
      do_reset();

      // Ideal raster: lock after the third VRESET
      repeat (4) frame_std(LINES);
      status_check("ideal");

      // One short frame: error, lock held, then back to locked silently
      frame_std(LINES - 2);
      status_check("short");
      frame_std(LINES);
      status_check("short_recover");

      // Two long frames drop lock; good frames relock
      repeat (2) frame_std(LINES + 3);
      status_check("long");
      repeat (3) frame_std(LINES);
      status_check("relock");

      // VRESET missing: timeout frame, then normal frames
      repeat (TIMEOUT) send_line(PIXELS, 1, 1'b0, 0, 0);
      status_check("timeout");
      repeat (2) frame_std(LINES);
      status_check("timeout_recover");

      // One short line, then a wide HRESET, inside a correct-length frame
      send_line(PIXELS - 5, 1, 1'b0, 0, 0);
      send_line(PIXELS, 3, 1'b0, 0, 0);
      repeat (LINES - 3) send_line(PIXELS, 1, 1'b0, 0, 0);
      send_line(PIXELS, 1, 1'b1, 0, 1);
      status_check("line_err");

      // Reset in the middle of a frame, then reacquire
      repeat (5) send_line(PIXELS, 1, 1'b0, 0, 0);
      do_reset();
      repeat (3) send_line(PIXELS, 1, 1'b0, 0, 0);
      repeat (3) frame_std(LINES);
      status_check("after_reset");

      // Randomised rasters
      for (int f = 0; f < 20; f++) begin
         random_frame();
         status_check("rand");
      end

      HRESET = 1'b0;
      VRESET = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
